// File: rtl/demo_clock_ctrl_if.sv
// Control bundle between the board pins and the demo clock controller:
// mode/speed/button/burst inputs in, tick enable and status out.
interface demo_clock_ctrl_if #(
  parameter int BURST_WIDTH = 8
);
  logic [1:0]             mode;
  logic [1:0]             speed;
  logic                   step_btn;
  logic [BURST_WIDTH-1:0] burst_len;
  logic                   tick;
  logic                   clk_slow;
  logic                   busy;
  logic [15:0]            tick_count;

  modport master (
    output mode, speed, step_btn, burst_len,
    input  tick, clk_slow, busy, tick_count
  );

  modport slave (
    input  mode, speed, step_btn, burst_len,
    output tick, clk_slow, busy, tick_count
  );
endinterface

// File: rtl/demo_clock_ctrl.sv
// Clock-enable controller for board demos: divides fastclk into a one-cycle tick and a
// clk_slow square wave, with halt, run, debounced single-step and N-step burst modes.
module demo_clock_ctrl #(
  parameter int DIV_DEFAULT     = 5_000_000,
  parameter int DIV_WIDTH       = 23,
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int BURST_WIDTH     = 8
) (
  input logic              fastclk,
  input logic              reset,
  demo_clock_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, BURST = 2'd2} state_t;

  localparam logic [1:0] MODE_RUN   = 2'b01;
  localparam logic [1:0] MODE_STEP  = 2'b10;
  localparam logic [1:0] MODE_BURST = 2'b11;

  localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

  logic                   sync1_reg;
  logic                   sync2_reg;
  logic                   deb_level_reg;
  logic [DEB_W-1:0]       deb_cnt_reg;
  logic                   step_req_reg;

  logic [1:0]             mode_q;
  logic [1:0]             speed_q;
  state_t                 state_reg;
  logic [DIV_WIDTH-1:0]   div_cnt_reg;
  logic [BURST_WIDTH-1:0] remaining_reg;
  logic                   tick_reg;
  logic                   clk_slow_reg;
  logic                   busy_reg;
  logic [15:0]            tick_count_reg;

  logic [DIV_WIDTH-1:0]   tc_tab [4];
  logic [DIV_WIDTH-1:0]   tc;
  logic                   mode_chg;
  logic                   due;
  logic                   step_fire;
  logic                   burst_start;
  logic                   issue;

  // Terminal count per speed setting, clamped so a tick never lasts two cycles.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_tc
      localparam int SHIFTED = DIV_DEFAULT >> (2 * gi);
      localparam int TC_VAL  = (SHIFTED > 2) ? SHIFTED - 1 : 1;
      assign tc_tab[gi] = DIV_WIDTH'(TC_VAL);
    end
  endgenerate

  always_ff @(posedge fastclk) begin
    if (reset) begin
      sync1_reg     <= 1'b0;
      sync2_reg     <= 1'b0;
      deb_level_reg <= 1'b0;
      deb_cnt_reg   <= '0;
      step_req_reg  <= 1'b0;
    end else begin
      sync1_reg    <= bus.step_btn;
      sync2_reg    <= sync1_reg;
      step_req_reg <= 1'b0;
      if (sync2_reg != deb_level_reg) begin
        if (deb_cnt_reg == DEB_LAST) begin
          deb_level_reg <= sync2_reg;
          deb_cnt_reg   <= '0;
          step_req_reg  <= sync2_reg;
        end else begin
          deb_cnt_reg <= deb_cnt_reg + 1'b1;
        end
      end else begin
        deb_cnt_reg <= '0;
      end
    end
  end

  assign tc          = tc_tab[speed_q];
  assign mode_chg    = (bus.mode != mode_q) || (bus.speed != speed_q);
  assign due         = (state_reg != IDLE) && (div_cnt_reg == tc);
  assign step_fire   = (state_reg == IDLE) && step_req_reg && (mode_q == MODE_STEP);
  assign burst_start = (state_reg == IDLE) && step_req_reg && (mode_q == MODE_BURST)
                       && (bus.burst_len != '0);
  // A mode/speed change in the same cycle as a due or step suppresses the tick.
  assign issue       = !mode_chg && (due || step_fire);

  always_ff @(posedge fastclk) begin
    if (reset) begin
      mode_q         <= 2'b00;
      speed_q        <= 2'b00;
      state_reg      <= IDLE;
      div_cnt_reg    <= '0;
      remaining_reg  <= '0;
      tick_reg       <= 1'b0;
      clk_slow_reg   <= 1'b0;
      busy_reg       <= 1'b0;
      tick_count_reg <= '0;
    end else begin
      mode_q   <= bus.mode;
      speed_q  <= bus.speed;
      tick_reg <= issue;
      if (issue) begin
        clk_slow_reg   <= ~clk_slow_reg;
        tick_count_reg <= tick_count_reg + 16'd1;
      end
      if (mode_chg) begin
        state_reg     <= (bus.mode == MODE_RUN) ? RUN : IDLE;
        div_cnt_reg   <= '0;
        remaining_reg <= '0;
        busy_reg      <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (mode_q == MODE_RUN) begin
              state_reg <= RUN;
            end else if (burst_start) begin
              state_reg     <= BURST;
              remaining_reg <= bus.burst_len;
              busy_reg      <= 1'b1;
              // The entry edge is the first divider cycle, so the first burst
              // tick lands TC+1 cycles after step_req.
              div_cnt_reg   <= DIV_WIDTH'(1);
            end
          end
          RUN: begin
            div_cnt_reg <= due ? '0 : div_cnt_reg + 1'b1;
          end
          BURST: begin
            div_cnt_reg <= due ? '0 : div_cnt_reg + 1'b1;
            if (due) begin
              remaining_reg <= remaining_reg - 1'b1;
              if (remaining_reg == BURST_WIDTH'(1)) begin
                state_reg <= IDLE;
                busy_reg  <= 1'b0;
              end
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign bus.tick       = tick_reg;
  assign bus.clk_slow   = clk_slow_reg;
  assign bus.busy       = busy_reg;
  assign bus.tick_count = tick_count_reg;
endmodule

// File: doc/demo_clock_ctrl.md
# demo_clock_ctrl

Parametrised clock-enable controller for board-level demo and test of the processor core on the Altera DE0. It divides the 50 MHz board clock into a one-cycle `tick` enable and a legacy `clk_slow` square wave. Beyond plain free-running division, it adds selectable speed, halt, debounced single-step and N-step burst modes. It sits between the board pins (switches and button) and the core's clock/enable input in the board test top level.

## Interface
- `DIV_DEFAULT`, 5_000_000: base divide ratio; 10 Hz tick at 50 MHz with speed 0.
- `DIV_WIDTH`, 23: divider counter width; must hold `DIV_DEFAULT-1`.
- `DEBOUNCE_CYCLES`, 500_000: consecutive identical samples required to accept a new button level (10 ms).
- `BURST_WIDTH`, 8: width of the burst length input and the remaining-step counter.
- `fastclk`  in  1  board clock; single clock domain; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `mode`  in  2  operating mode: 00 halt, 01 run, 10 step, 11 burst; synchronous to `fastclk`.
- `speed`  in  2  divide selection: terminal count TC = max((DIV_DEFAULT >> (2*speed)) - 1, 1).
- `step_btn`  in  1  raw, asynchronous push-button, active-high.
- `burst_len`  in  BURST_WIDTH  number of ticks issued per burst; sampled at burst start.
- `tick`  out  1  registered one-`fastclk`-cycle enable pulse.
- `clk_slow`  out  1  registered; toggles on every tick.
- `busy`  out  1  high while a burst is in progress.
- `tick_count`  out  16  count of ticks issued; wraps 0xFFFF -> 0x0000.

## Operation
- **Input conditioning**
  - `step_btn` passes through a 2-flop synchroniser, then the debouncer.
  - The debounced level changes only after `DEBOUNCE_CYCLES` consecutive samples differ from the current level. Any matching sample restarts the count.
  - A 0->1 change of the debounced level produces `step_req`, a single-cycle internal pulse.
- **Mode and speed registers**
  - `mode` and `speed` are registered as `mode_q` and `speed_q`.
  - Any cycle in which the new value differs from the registered value clears the divider and aborts a burst.
- **Divider**
  - `div_cnt` counts 0..TC and asserts `due` when it is at TC, then returns to 0.
  - It counts only in state RUN or BURST; otherwise it is held at 0.
- **FSM states**
  - IDLE: covers modes halt and step.
  - RUN: entered whenever `mode_q`=01; each `due` issues a tick.
  - BURST: entered from IDLE when `mode_q`=11, `step_req` fires and `burst_len` != 0. The entry cycle loads `remaining` <= `burst_len`. Each `due` issues a tick and decrements `remaining`. The tick that takes `remaining` to 0 returns the FSM to IDLE.
- **Step mode**: in IDLE with `mode_q`=10, `step_req` issues exactly one tick.
- **Ignored or aborted requests**
  - In halt, `step_req` is ignored.
  - In burst mode, `step_req` is ignored while BURST is active; no re-trigger and no accumulation.
  - `burst_len`=0 produces no ticks, and `busy` stays low.
  - A mode change during BURST aborts the burst: `remaining` <= 0 and the FSM goes to the state for the new mode. No further burst ticks are issued.
- **Per-tick updates**: `tick_count` increments and `clk_slow` inverts, in the same cycle `tick` is high.
- **Simultaneous events**: mode change and `due` in the same cycle → the mode change wins and no tick is issued.

## Timing
- **Reset values**: `tick`=0, `clk_slow`=0, `busy`=0, `tick_count`=0, state IDLE, `div_cnt`=0, `remaining`=0, debounced level=0, synchroniser flops=0.
- **Reset mid-operation**: all of the above are applied on the next edge. A pending burst or debounce in progress is discarded.
- **Button held through reset**: yields one `step_req` `DEBOUNCE_CYCLES`+2 cycles after reset deasserts.
- **Run period**: exactly TC+1 `fastclk` cycles between ticks. The first tick comes TC+1 cycles after `mode_q` becomes 01.
- **Button latency**: edge on `step_btn` -> `step_req` at 2 (sync) + `DEBOUNCE_CYCLES` cycles.
- **Step latency**: `step_req` -> `tick` high on the next cycle (1 cycle).
- **Burst timing**
  - First burst tick comes TC+1 cycles after the `step_req` cycle; subsequent ticks are TC+1 apart.
  - `busy` rises the cycle after `step_req` and falls in the same edge that registers the last tick.
- **Pulse width**: `tick` is never high for two consecutive cycles, since TC >= 1.

## Test plan
All scenarios use `DIV_DEFAULT`=8, `DEBOUNCE_CYCLES`=4.

1. **Run mode, speed sweep**
   - Stimulus: reset 3 cycles, then `mode`=01, `speed`=0 for 40 cycles.
   - Required: ticks exactly 8 cycles apart, first at 8 cycles after `mode_q`=01, `clk_slow` toggles per tick.
   - Then `speed`=1 (TC=1): ticks every 2 cycles. `speed`=3 (TC clamps to 1): ticks every 2 cycles.
2. **Debounced single step**
   - Stimulus: `mode`=10; `step_btn` bounces 1/0/1 at 1-cycle intervals, then held high 10 cycles, then released.
   - Required: exactly one tick, 2+4+1 cycles after the final stable rise; `tick_count`=1.
   - A release followed by a press shorter than 4 cycles gives no tick.
3. **Burst**
   - Stimulus: `mode`=11, `burst_len`=3, one clean press.
   - Required: 3 ticks at 8-cycle spacing, `busy` high from the cycle after `step_req` to the last tick, `tick_count`=3.
   - A second press mid-burst adds nothing.
   - With `burst_len`=0, a press gives no tick and `busy` stays 0.
4. **Burst abort**
   - Stimulus: during a 5-tick burst after 2 ticks, `mode` -> 00.
   - Required: no further ticks, `busy`=0, `remaining`=0, `tick_count`=2.
5. **Wrap-around and reset**
   - Stimulus: force 65535 ticks in run mode with `speed`=3.
   - Required: `tick_count` wraps to 0 on the next tick.
   - Assert `reset` mid-burst: all outputs return to reset values on the next edge.
   - Holding `step_btn` high through reset gives one tick in step mode 7 cycles after release of reset.
